// File: rtl/median_window_feeder.sv
// median_window_feeder
// Valid/ready wrapper around a 6-input combinational median finder.
// Keeps a 6-sample sliding window (num1 newest, num6 oldest) that feeds the
// finder. Once the window is full, every new sample triggers one capture of
// the finder's result. The captured median is held on out_data until
// downstream accepts it. The only combinational path through the block is
// out_ready -> in_ready while a result is being held.

module median_window_feeder #(
    parameter int WIDTH = 4,
    parameter int WIN   = 6     // fixed: the finder has exactly six inputs
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] num1,
    output logic [WIDTH-1:0] num2,
    output logic [WIDTH-1:0] num3,
    output logic [WIDTH-1:0] num4,
    output logic [WIDTH-1:0] num5,
    output logic [WIDTH-1:0] num6,
    input  logic [WIDTH-1:0] med_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [2:0]       fill_cnt
);

    // FILL: window not yet full. CAPTURE: one cycle to register the median.
    // HOLD: result presented, waiting for out_ready. STREAM: window full, idle.
    localparam logic [1:0] ST_FILL    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_HOLD    = 2'd2;
    localparam logic [1:0] ST_STREAM  = 2'd3;

    localparam logic [2:0] FILL_FULL = 3'd6;
    localparam logic [2:0] FILL_LAST = 3'd5;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] win_q [WIN];
    logic [WIDTH-1:0] win_d [WIN];
    logic [2:0]       fill_q, fill_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             in_ready_s;
    logic             accept_s;

    // Ready decode: free while filling or streaming, blocked during capture,
    // and tied to out_ready while holding a result so a consume can overlap
    // with the next accept.
    always_comb begin
        in_ready_s = 1'b0;
        case (state_q)
            ST_FILL:    in_ready_s = 1'b1;
            ST_CAPTURE: in_ready_s = 1'b0;
            ST_HOLD:    in_ready_s = out_ready;
            ST_STREAM:  in_ready_s = 1'b1;
            default:    in_ready_s = 1'b0;
        endcase
    end

    assign accept_s = in_valid && in_ready_s;

    // Next-state logic: clear wins over everything. Otherwise an accepted
    // sample shifts the window and the FSM sequences capture and hold.
    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        for (int i = 0; i < WIN; i++) begin
            win_d[i] = win_q[i];
        end

        if (clear) begin
            for (int i = 0; i < WIN; i++) begin
                win_d[i] = {WIDTH{1'b0}};
            end
            fill_d      = 3'd0;
            out_valid_d = 1'b0;
            out_data_d  = {WIDTH{1'b0}};
            state_d     = ST_FILL;
        end else begin
            if (accept_s) begin
                for (int i = WIN - 1; i > 0; i--) begin
                    win_d[i] = win_q[i-1];
                end
                win_d[0] = in_data;
                if (fill_q == FILL_FULL) begin
                    fill_d = FILL_FULL;
                end else begin
                    fill_d = fill_q + 3'd1;
                end
            end else begin
                fill_d = fill_q;
            end

            case (state_q)
                ST_FILL: begin
                    if (accept_s && (fill_q == FILL_LAST)) begin
                        state_d = ST_CAPTURE;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
                ST_CAPTURE: begin
                    // The window has been stable for a full cycle, so
                    // med_in has settled.
                    out_data_d  = med_in;
                    out_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        if (accept_s) begin
                            state_d = ST_CAPTURE;
                        end else begin
                            state_d = ST_STREAM;
                        end
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                ST_STREAM: begin
                    if (accept_s) begin
                        state_d = ST_CAPTURE;
                    end else begin
                        state_d = ST_STREAM;
                    end
                end
                default: begin
                    state_d     = ST_FILL;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FILL;
            fill_q      <= 3'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= {WIDTH{1'b0}};
            for (int i = 0; i < WIN; i++) begin
                win_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            for (int i = 0; i < WIN; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign num1      = win_q[0];
    assign num2      = win_q[1];
    assign num3      = win_q[2];
    assign num4      = win_q[3];
    assign num5      = win_q[4];
    assign num6      = win_q[5];
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign fill_cnt  = fill_q;

endmodule
